seconds_units: RTL and testbench
================================

// Module: seconds_units
// PURPOSE
//  Units-of-seconds stage of the full clock. Divides the board clock to a 1 Hz
//  tick, counts 0..9, drives one active-low 7-segment digit and produces the
//  carry that clocks the downstream tens stage on its falling edge.
//  Sits between the board clock pin and the tens (0..5) digit stage.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency in Hz
//  TICK_HZ  1           count rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer >= 2.
// PORTS
//  clk          in   1  board clock; all logic on the rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  run          in   1  count enable; 0 freezes prescaler and digit
//  clr          in   1  synchronous clear; priority over run
//  digit        out  4  current BCD value, 0..9
//  Display      out  7  segments {g,f,e,d,c,b,a}, active low
//  c            out  1  carry level to tens stage: 1 while digit==9
//  carry_pulse  out  1  1-cycle strobe on 9->0 wrap, for synchronous consumers
//  dp           out  1  decimal point, active low (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): prescaler=0, digit=0, Display=7'b1000000, c=0,
//   carry_pulse=0, dp=1. Outputs hold these values until the first clk edge after release.
//  Prescaler: counter, width $clog2(DIV); counts 0..DIV-1 while run=1.
//   tick=1 for exactly one cycle when prescaler==DIV-1 && run; prescaler then wraps to 0.
//  Digit: on tick, digit <= (digit==9) ? 0 : digit+1.
//   Display, c and digit are all registered on the same edge, so there is
//   zero cycles of skew between them.
//  Seg table, 0..9: 1000000 1111001 0100100 0110000 0011001 0010010 0000010
//   1111000 0000000 0010000. An unreachable code (10..15) drives 1111111 and
//   forces digit to 0 on the next edge.
//  c = registered (digit==9). Its falling edge coincides with the 9->0 wrap,
//   which yields one tens-stage increment per 10 ticks.
//  carry_pulse=1 in the same cycle that digit first reads 0 after a 9->0 tick wrap.
//   It is 0 on every other cycle.
//  run=0: prescaler, digit and all outputs hold. No tick is generated.
//   When run returns to 1, counting resumes from the held prescaler value.
//  clr=1: prescaler=0, digit=0, Display=1000000, c=0, carry_pulse=0 on the next edge.
//   clr while digit==9 drops c. The downstream stage then sees a falling edge;
//   this is the intended behaviour.
//   carry_pulse is never asserted by clr.
//  clr and tick in the same cycle: clr wins and the tick is discarded.
//  rst_n asserted mid-count: immediate return to reset values, with no carry edge generated.
// CONFIGURATION
//  Macro DP_BLINK_EN:
//   defined     -> dp=0 (lit) for prescaler < DIV/2, dp=1 otherwise, giving a 50% seconds blink.
//                  dp holds while run=0 and is 1 under reset/clr.
//   not defined -> dp tied to 1 (off). The port remains present, so there is
//                  no pinout difference.
// TESTING  (CLK_HZ=10, TICK_HZ=1 -> DIV=10)
//  1. Release rst_n, run=1 -> first tick at cycle 10; digit=1, Display=1111001.
//  2. Run 100 cycles -> digit steps 0..9. c rises when digit=9, then falls at
//     the 9->0 edge together with a single carry_pulse.
//  3. run=0 at digit=4, prescaler=6, for 37 cycles -> no change.
//     run=1 -> digit becomes 5 exactly 4 cycles later.
//  4. clr asserted on the cycle a tick is due at digit=9 -> digit=0, c=0,
//     carry_pulse=0, Display=1000000.
//  5. rst_n pulsed low mid-count at digit=7 -> outputs immediately read the
//     reset values. Counting restarts from 0 with a full 10-cycle period.
//  6. DP_BLINK_EN defined -> dp=0 for prescaler 0..4 and dp=1 for 5..9 every second.
//     Undefined -> dp=1 constantly.

Source files
------------

// File: rtl/seconds_units.sv
// ============================================================================
// Module   : seconds_units
// Brief    : Units-of-seconds digit: 1 Hz prescaler, 0..9 BCD counter,
//            active-low 7-seg driver and carry to the tens stage.
//            Optional macro DP_BLINK_EN enables a 50% decimal-point blink.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seconds_units #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clr,
  output logic [3:0] digit,
  output logic [6:0] Display,
  output logic       c,
  output logic       carry_pulse,
  output logic       dp
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  localparam logic [PW-1:0] c_PRESC_MAX = PW'(DIV - 1);
  localparam logic [3:0]    c_DIGIT_MAX = 4'd9;
  localparam logic [6:0]    c_SEG_ZERO  = 7'b1000000;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PW-1:0] r_presc;
  logic [3:0]    r_digit;
  logic [6:0]    r_seg;
  logic          r_c;
  logic          r_cp;

  logic [PW-1:0] w_presc_nxt;
  logic [3:0]    w_digit_nxt;
  logic          w_tick;
  logic          w_wrap;

  always_comb begin
    w_tick      = run && (r_presc == c_PRESC_MAX);
    w_presc_nxt = r_presc;
    w_digit_nxt = r_digit;
    w_wrap      = 1'b0;
    if (clr) begin
      w_presc_nxt = '0;
      w_digit_nxt = '0;
    end else begin
      if (run) begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
      end
      // Out-of-range codes self-recover even while frozen.
      if (r_digit > c_DIGIT_MAX) begin
        w_digit_nxt = '0;
      end else if (w_tick) begin
        if (r_digit == c_DIGIT_MAX) begin
          w_digit_nxt = '0;
          w_wrap      = 1'b1;
        end else begin
          w_digit_nxt = r_digit + 4'd1;
        end
      end
    end
  end

  // Segments and carry derive from the next digit so all three share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_digit <= '0;
      r_seg   <= c_SEG_ZERO;
      r_c     <= 1'b0;
      r_cp    <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_digit <= w_digit_nxt;
      r_seg   <= f_seg(w_digit_nxt);
      r_c     <= (w_digit_nxt == c_DIGIT_MAX);
      r_cp    <= w_wrap;
    end
  end

  assign digit       = r_digit;
  assign Display     = r_seg;
  assign c           = r_c;
  assign carry_pulse = r_cp;

`ifdef DP_BLINK_EN
  localparam logic [PW-1:0] c_HALF = PW'(DIV / 2);

  logic r_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp <= 1'b1;
    end else if (clr) begin
      r_dp <= 1'b1;
    end else if (run) begin
      r_dp <= (w_presc_nxt >= c_HALF);
    end
  end

  assign dp = r_dp;
`else
  assign dp = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seconds_units.sv
// ============================================================================
// Module   : tb_seconds_units
// Brief    : Self-checking bench for seconds_units with DIV=10, compared
//            against a per-edge arithmetic model of the counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seconds_units;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       run   = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] digit;
  logic [6:0] Display;
  logic       c;
  logic       carry_pulse;
  logic       dp;

  seconds_units #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .clr         (clr),
    .digit       (digit),
    .Display     (Display),
    .c           (c),
    .carry_pulse (carry_pulse),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_presc;
  int m_digit;
  int m_cp;
  bit m_fresh;

  logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  localparam logic [13:0] RESET_VEC = {4'd0, 7'b1000000, 1'b0, 1'b0, 1'b1};

  logic [13:0] obs;
  assign obs = {digit, Display, c, carry_pulse, dp};

  function automatic logic [13:0] exp_vec();
    logic dp_e;
`ifdef DP_BLINK_EN
    dp_e = m_fresh ? 1'b1 : (m_presc >= DIV / 2);
`else
    dp_e = 1'b1;
`endif
    return {4'(m_digit), SEG_TBL[m_digit], (m_digit == 9), m_cp[0], dp_e};
  endfunction

  task automatic model_reset();
    m_presc = 0;
    m_digit = 0;
    m_cp    = 0;
    m_fresh = 1'b1;
  endtask

  // One clock edge with the given inputs, then advance the model.
  task automatic step(input logic r, input logic k);
    run = r;
    clr = k;
    @(posedge clk);
    if (k) begin
      model_reset();
    end else if (r) begin
      m_fresh = 1'b0;
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_cp    = (m_digit == 9) ? 1 : 0;
        m_digit = (m_digit + 1) % 10;
      end else begin
        m_presc = m_presc + 1;
        m_cp    = 0;
      end
    end else begin
      m_cp = 0;
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    run   = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_async: got %b expected %b", obs, RESET_VEC);
    end
    step(1'b1, 1'b0);
    model_reset();
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_held: got %b expected %b", obs, RESET_VEC);
    end
    release_reset();
  endtask

  task automatic test_count();
    int pulses = 0;
    pulse_reset();
    release_reset();
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b0);
      if (carry_pulse === 1'b1) pulses++;
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL count cyc=%0d: got %b expected %b", i, obs, exp_vec());
      end
      if (i == 10) begin
        total++;
        if (digit !== 4'd1 || Display !== 7'b1111001) begin
          bad++;
          $display("FAIL first_tick: got digit=%0d seg=%b expected 1/1111001", digit, Display);
        end
      end
    end
    total++;
    if (pulses != 1 || digit !== 4'd0) begin
      bad++;
      $display("FAIL wrap_pulses: got pulses=%0d digit=%0d expected 1/0", pulses, digit);
    end
  endtask

  task automatic test_hold();
    pulse_reset();
    release_reset();
    for (int i = 0; i < 46; i++) step(1'b1, 1'b0);
    total++;
    if (digit !== 4'd4) begin
      bad++;
      $display("FAIL hold_setup: got digit=%0d expected 4", digit);
    end
    for (int i = 0; i < 37; i++) begin
      step(1'b0, 1'b0);
      total++;
      if (obs !== exp_vec() || digit !== 4'd4) begin
        bad++;
        $display("FAIL hold cyc=%0d: got %b expected %b", i, obs, exp_vec());
      end
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (digit !== ((i == 4) ? 4'd5 : 4'd4)) begin
        bad++;
        $display("FAIL resume cyc=%0d: got digit=%0d expected %0d", i, digit, (i == 4) ? 5 : 4);
      end
    end
  endtask

  task automatic test_clr_tick();
    pulse_reset();
    release_reset();
    for (int i = 0; i < 99; i++) step(1'b1, 1'b0);
    total++;
    if (digit !== 4'd9 || c !== 1'b1) begin
      bad++;
      $display("FAIL clr_setup: got digit=%0d c=%b expected 9/1", digit, c);
    end
    step(1'b1, 1'b1);
    total++;
    if (digit !== 4'd0 || c !== 1'b0 || carry_pulse !== 1'b0 || Display !== 7'b1000000) begin
      bad++;
      $display("FAIL clr_tick: got d=%0d c=%b cp=%b seg=%b expected 0/0/0/1000000",
               digit, c, carry_pulse, Display);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL after_clr cyc=%0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    release_reset();
    for (int i = 0; i < 75; i++) step(1'b1, 1'b0);
    total++;
    if (digit !== 4'd7) begin
      bad++;
      $display("FAIL mid_setup: got digit=%0d expected 7", digit);
    end
    pulse_reset();
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_mid: got %b expected %b", obs, RESET_VEC);
    end
    release_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (digit !== ((i == 10) ? 4'd1 : 4'd0) || obs !== exp_vec()) begin
        bad++;
        $display("FAIL restart cyc=%0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    pulse_reset();
    release_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_hold();
    test_clr_tick();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
